// File: rtl/sdram_arbiter_if.sv
// Controller-side burst bus of the SDRAM arbiter.
// The master side is the arbiter; the slave side is the burst controller.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 22,
    parameter int LEN_W  = 9,
    parameter int DATA_W = 16
);
    logic              ctl_req;
    logic              ctl_wr;
    logic [ADDR_W-1:0] ctl_addr;
    logic [LEN_W-1:0]  ctl_len;
    logic              ctl_ack;
    logic [DATA_W-1:0] ctl_wdata;
    logic              ctl_wdata_rd;
    logic [DATA_W-1:0] ctl_rdata;
    logic              ctl_rdata_vld;
    logic              ctl_done;

    modport master (
        output ctl_req,
        output ctl_wr,
        output ctl_addr,
        output ctl_len,
        output ctl_wdata,
        input  ctl_ack,
        input  ctl_wdata_rd,
        input  ctl_rdata,
        input  ctl_rdata_vld,
        input  ctl_done
    );

    modport slave (
        input  ctl_req,
        input  ctl_wr,
        input  ctl_addr,
        input  ctl_len,
        input  ctl_wdata,
        output ctl_ack,
        output ctl_wdata_rd,
        output ctl_rdata,
        output ctl_rdata_vld,
        output ctl_done
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM burst controller between the video write channel
// and the display read channel; urgent reads win, otherwise round-robin.
module sdram_arbiter #(
    parameter int ADDR_W = 22,
    parameter int LEN_W  = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic              rd_urgent,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    sdram_arbiter_if.master   ctl,
    output logic              len_err,
    output logic              busy
);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_REQ  = 4'b0010,
        S_BUSY = 4'b0100,
        S_DONE = 4'b1000
    } state_e;

    state_e            state_q, state_d;
    logic              grant_rd_q, grant_rd_d;
    logic              last_rd_q, last_rd_d;
    logic              ctl_req_q, ctl_req_d;
    logic              ctl_wr_q, ctl_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic [LEN_W:0]    beat_q, beat_d;
    logic              len_err_q, len_err_d;

    logic              pick_rd;
    logic              pick_wr;
    logic [LEN_W-1:0]  pick_len;
    logic              beat;
    logic [LEN_W:0]    beat_sum;
    logic              in_busy;

    assign in_busy  = (state_q == S_BUSY);
    assign pick_rd  = rd_req & (rd_urgent | ~wr_req | ~last_rd_q);
    assign pick_wr  = ~pick_rd & wr_req;
    assign pick_len = pick_rd ? rd_len : wr_len;

    // A beat only counts on the strobe that belongs to the granted direction.
    assign beat = in_busy &
                  (grant_rd_q ? ctl.ctl_rdata_vld : ctl.ctl_wdata_rd);
    assign beat_sum = (beat && (beat_q != '1))
                    ? beat_q + 1'b1 : beat_q;

    always_comb begin
        state_d    = state_q;
        grant_rd_d = grant_rd_q;
        last_rd_d  = last_rd_q;
        ctl_req_d  = ctl_req_q;
        ctl_wr_d   = ctl_wr_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wr_ack_d   = 1'b0;
        rd_ack_d   = 1'b0;
        beat_d     = beat_q;
        len_err_d  = len_err_q;

        unique case (1'b1)
            (state_q == S_IDLE): begin
                if (frame_rst) begin
                    last_rd_d = 1'b1;
                end else if (pick_rd || pick_wr) begin
                    grant_rd_d = pick_rd;
                    ctl_wr_d   = ~pick_rd;
                    addr_d     = pick_rd ? rd_addr : wr_addr;
                    len_d      = pick_len;
                    if (pick_len == '0) begin
                        wr_ack_d = pick_wr;
                        rd_ack_d = pick_rd;
                        state_d  = S_DONE;
                    end else begin
                        ctl_req_d = 1'b1;
                        state_d   = S_REQ;
                    end
                end
            end
            (state_q == S_REQ): begin
                // Once the controller has accepted, the burst must run.
                if (ctl.ctl_ack) begin
                    ctl_req_d = 1'b0;
                    wr_ack_d  = ~grant_rd_q;
                    rd_ack_d  = grant_rd_q;
                    beat_d    = '0;
                    state_d   = S_BUSY;
                end else if (frame_rst) begin
                    ctl_req_d = 1'b0;
                    last_rd_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            (state_q == S_BUSY): begin
                beat_d = beat_sum;
                if (ctl.ctl_done) begin
                    if (beat_sum != {1'b0, len_q}) begin
                        len_err_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            (state_q == S_DONE): begin
                last_rd_d = grant_rd_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_rd_q <= 1'b1;
            last_rd_q  <= 1'b1;
            ctl_req_q  <= 1'b0;
            ctl_wr_q   <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            beat_q     <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_rd_q <= grant_rd_d;
            last_rd_q  <= last_rd_d;
            ctl_req_q  <= ctl_req_d;
            ctl_wr_q   <= ctl_wr_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            beat_q     <= beat_d;
            len_err_q  <= len_err_d;
        end
    end

    assign ctl.ctl_req   = ctl_req_q;
    assign ctl.ctl_wr    = ctl_wr_q;
    assign ctl.ctl_addr  = addr_q;
    assign ctl.ctl_len   = len_q;
    assign ctl.ctl_wdata = (in_busy && !grant_rd_q) ? wr_data : '0;

    assign rd_data  = (in_busy && grant_rd_q) ? ctl.ctl_rdata : '0;
    assign rd_valid = in_busy & grant_rd_q & ctl.ctl_rdata_vld;
    assign wr_ack   = wr_ack_q;
    assign rd_ack   = rd_ack_q;
    assign len_err  = len_err_q;
    assign busy     = (state_q != S_IDLE);

endmodule
